spi_ram_ctrl: RTL and testbench

//   Command-decoding single-port RAM that sits directly downstream of the SPI slave.
//   It consumes the slave's 10-bit rx_data/rx_valid words and executes address-latch,

---
 rtl/spi_ram_ctrl.sv | 105 ++++++++++
 tb/tb_spi_ram_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM fed by the SPI slave's rx_data/rx_valid words.
// Address-latch, write and read commands; both pointers auto-increment and wrap.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);
  localparam int                   IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_LOW} state_t;
  state_t state, state_nxt;

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_vld, rd_vld, rx_valid_q;
  logic                 accept, in_range;
  logic                 do_wa, do_wd, do_ra, do_rd, do_err;
  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload;

  assign cmd      = din[ADDR_SIZE+1:ADDR_SIZE];
  assign payload  = din[ADDR_SIZE-1:0];
  assign in_range = {1'b0, payload} < DEPTH;

  function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept)    state_nxt = EXEC;
      EXEC:     state_nxt = rx_valid ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!rx_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Acceptance is purely the rx_valid rising edge; the FSM only tracks the handshake.
  always_comb begin
    accept = rx_valid & ~rx_valid_q;
    do_wa  = 1'b0;
    do_wd  = 1'b0;
    do_ra  = 1'b0;
    do_rd  = 1'b0;
    do_err = 1'b0;
    if (accept) begin
      case (cmd)
        2'b00:   if (in_range) do_wa = 1'b1; else do_err = 1'b1;
        2'b01:   if (wr_vld)   do_wd = 1'b1; else do_err = 1'b1;
        2'b10:   if (in_range) do_ra = 1'b1; else do_err = 1'b1;
        default: if (rd_vld)   do_rd = 1'b1; else do_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_vld     <= 1'b0;
      rd_vld     <= 1'b0;
      dout       <= '0;
      tx_valid   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      tx_valid   <= do_rd;
      cmd_err    <= do_err;
      if (do_wa) begin
        wr_addr <= payload;
        wr_vld  <= 1'b1;
      end
      if (do_wd) wr_addr <= inc(wr_addr);
      if (do_ra) begin
        rd_addr <= payload;
        rd_vld  <= 1'b1;
      end
      if (do_rd) begin
        dout    <= mem[rd_addr[IW-1:0]];
        rd_addr <= inc(rd_addr);
      end
    end
  end

  // Array contents survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && do_wd) mem[wr_addr[IW-1:0]] <= payload;
  end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (depth 256 and 100) share one stimulus stream
// and are checked every cycle against a command-level model, plus literal scenario checks.
module tb_spi_ram_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout0, dout1;
  logic       tx0, tx1, err0, err1;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout0), .tx_valid(tx0), .cmd_err(err0));
  spi_ram_ctrl #(.MEM_DEPTH(100), .ADDR_SIZE(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout1), .tx_valid(tx1), .cmd_err(err1));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Command-level model: per instance memory with known-flags, pointers, expected outputs.
  int       depth [2] = '{256, 100};
  bit [7:0] mm [2][256];
  bit       kn [2][256];
  int       wa [2], ra [2], mp;
  bit       wv [2], rv [2];
  bit [7:0] e_dout [2];
  bit       e_dk [2], e_tx [2], e_err [2];
  bit       m_prev = 1'b0, seen_rst = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_tx[k]  = 1'b0;
      e_err[k] = 1'b0;
      if (!rst_n) begin
        wa[k] = 0; ra[k] = 0; wv[k] = 1'b0; rv[k] = 1'b0;
        e_dout[k] = 8'h00; e_dk[k] = 1'b1;
      end else if (rx_valid && !m_prev) begin
        mp = int'(din[7:0]);
        case (din[9:8])
          2'd0: if (mp < depth[k]) begin wa[k] = mp; wv[k] = 1'b1; end else e_err[k] = 1'b1;
          2'd1: if (wv[k]) begin
                  mm[k][wa[k]] = din[7:0];
                  kn[k][wa[k]] = 1'b1;
                  wa[k] = (wa[k] + 1) % depth[k];
                end else e_err[k] = 1'b1;
          2'd2: if (mp < depth[k]) begin ra[k] = mp; rv[k] = 1'b1; end else e_err[k] = 1'b1;
          default: if (rv[k]) begin
                  e_dout[k] = mm[k][ra[k]];
                  e_dk[k]   = kn[k][ra[k]];
                  e_tx[k]   = 1'b1;
                  ra[k] = (ra[k] + 1) % depth[k];
                end else e_err[k] = 1'b1;
        endcase
      end
    end
    m_prev = rst_n && rx_valid;
    if (!rst_n) seen_rst = 1'b1;
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      check("tx_valid0", 32'(tx0), 32'(e_tx[0]));
      check("cmd_err0", 32'(err0), 32'(e_err[0]));
      check("tx_valid1", 32'(tx1), 32'(e_tx[1]));
      check("cmd_err1", 32'(err1), 32'(e_err[1]));
      if (e_dk[0]) check("dout0", 32'(dout0), 32'(e_dout[0]));
      if (e_dk[1]) check("dout1", 32'(dout1), 32'(e_dout[1]));
    end
  end

  // Present a word for one accepting edge; returns #1 after that edge.
  task automatic cmd(input logic [9:0] w);
    @(posedge clk); #1;
    din = w; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] w;
    int         pulses, h, l;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset dout", 32'(dout0), 32'h00);
    check("reset tx_valid", 32'(tx0), 32'h0);
    check("reset cmd_err", 32'(err0), 32'h0);

    cmd(10'h300);
    check("rd without addr err", 32'(err0), 32'h1);
    check("rd without addr tx", 32'(tx0), 32'h0);
    check("rd without addr dout", 32'(dout0), 32'h00);
    @(posedge clk); #1;
    check("err pulse width", 32'(err0), 32'h0);

    cmd(10'h070);
    check("addr 112 depth100 err", 32'(err1), 32'h1);
    check("addr 112 depth256 ok", 32'(err0), 32'h0);
    cmd(10'h1EE);
    check("wr after bad addr err", 32'(err1), 32'h1);

    cmd(10'h005); cmd(10'h1A5); cmd(10'h13C); cmd(10'h205);
    cmd(10'h300);
    check("burst rd0 tx", 32'(tx0), 32'h1);
    check("burst rd0", 32'(dout0), 32'hA5);
    check("burst rd0 depth100", 32'(dout1), 32'hA5);
    @(posedge clk); #1;
    check("tx pulse width", 32'(tx0), 32'h0);
    check("dout holds", 32'(dout0), 32'hA5);
    cmd(10'h300);
    check("burst rd1", 32'(dout0), 32'h3C);

    cmd(10'h0FF);
    check("addr 255 depth100 err", 32'(err1), 32'h1);
    cmd(10'h111); cmd(10'h122); cmd(10'h200); cmd(10'h300);
    check("wrap read addr0", 32'(dout0), 32'h22);

    cmd(10'h205);
    @(posedge clk); #1;
    din = 10'h301; rx_valid = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      pulses += int'(tx0);
    end
    rx_valid = 1'b0;
    check("held rx_valid pulses", 32'(pulses), 32'd1);
    check("held rx_valid dout", 32'(dout0), 32'hA5);
    cmd(10'h300);
    check("rd_addr advanced by 1", 32'(dout0), 32'h3C);
    check("rd_addr advanced depth100", 32'(dout1), 32'h3C);

    cmd(10'h010); cmd(10'h155); cmd(10'h010);
    @(posedge clk); #1;
    din = 10'h1AA; rx_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset-write dout", 32'(dout0), 32'h00);
    check("reset-write tx", 32'(tx0), 32'h0);
    check("reset-write err", 32'(err0), 32'h0);
    rst_n = 1'b1; rx_valid = 1'b0;
    cmd(10'h177);
    check("wr after reset err", 32'(err0), 32'h1);
    cmd(10'h210); cmd(10'h300);
    check("no write under reset", 32'(dout0), 32'h55);
    check("no write under reset depth100", 32'(dout1), 32'h55);

    repeat (1500) begin
      if ($urandom_range(0, 63) == 0) begin
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
      end
      w[9:8] = 2'($urandom_range(0, 3));
      w[7:0] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 99)) : 8'($urandom_range(0, 255));
      h = int'($urandom_range(1, 3));
      l = int'($urandom_range(1, 2));
      @(posedge clk); #1;
      din = w; rx_valid = 1'b1;
      repeat (h) begin
        @(posedge clk); #1;
        if ($urandom_range(0, 3) == 0) din = 10'($urandom_range(0, 1023));
      end
      rx_valid = 1'b0;
      repeat (l - 1) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
